// File: rtl/card_list_mgr.sv
// Linked-list card store: N_LISTS lists plus a free list share one DEPTH-entry memory.
// Address 0 is the null pointer; commands arrive on a valid/ready port and answer with a one-cycle pulse.
module card_list_mgr #(
  parameter int DEPTH   = 64,
  parameter int VALUE_W = 4,
  parameter int SUIT_W  = 2,
  parameter int N_LISTS = 4,
  parameter int IDX_W   = 6,
  localparam int AW     = $clog2(DEPTH),
  localparam int LW     = (N_LISTS > 1) ? $clog2(N_LISTS) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LW-1:0]      cmd_list,
  input  logic [IDX_W-1:0]   cmd_idx,
  input  logic [VALUE_W-1:0] cmd_value,
  input  logic [SUIT_W-1:0]  cmd_suit,
  output logic               rsp_valid,
  output logic               rsp_err,
  output logic [VALUE_W-1:0] rsp_value,
  output logic [SUIT_W-1:0]  rsp_suit,
  output logic [AW:0]        free_count,
  output logic               init_done
);

  localparam int FW  = AW + 1;
  localparam int EW  = SUIT_W + VALUE_W + AW;
  localparam int NL2 = 1 << LW;
  localparam logic [LW:0] NL_LIM = (LW + 1)'(N_LISTS);

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_INS  = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_PEEK = 2'b11;

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_ALLOC, S_WALK, S_UNLINK, S_FREE, S_RESP
  } state_t;

  state_t state, state_nxt;

  logic [EW-1:0] mem [DEPTH];
  logic          mem_we;
  logic [AW-1:0] mem_wa;
  logic [EW-1:0] mem_wd;
  logic [AW-1:0] rd_addr;
  logic [EW-1:0] rd;
  logic [AW-1:0] rd_next;
  logic [VALUE_W-1:0] rd_value;
  logic [SUIT_W-1:0]  rd_suit;

  logic [NL2-1:0][AW-1:0] head;
  logic [AW-1:0] free_head;
  logic [AW-1:0] init_ptr;
  logic          init_last;
  logic          list_ok;

  // Captured command and walk context
  logic [1:0]         op_q;
  logic [LW-1:0]      list_q;
  logic [IDX_W-1:0]   idx_q;
  logic [VALUE_W-1:0] value_q;
  logic [SUIT_W-1:0]  suit_q;
  logic [AW-1:0]      cur, prev, cur_next;
  logic [IDX_W-1:0]   cnt;
  logic [VALUE_W-1:0] prev_value, res_value;
  logic [SUIT_W-1:0]  prev_suit, res_suit;
  logic               err_q;

  assign cmd_ready = (state == S_IDLE);
  assign init_last = (init_ptr == AW'(DEPTH - 1));
  assign list_ok   = ({1'b0, cmd_list} < NL_LIM);

  // Single combinational read port: free-list pop in ALLOC, walk pointer otherwise
  assign rd_addr  = (state == S_ALLOC) ? free_head : cur;
  assign rd       = mem[rd_addr];
  assign rd_next  = rd[AW-1:0];
  assign rd_value = rd[AW +: VALUE_W];
  assign rd_suit  = rd[AW + VALUE_W +: SUIT_W];

  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_INIT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    mem_wa    = init_ptr;
    mem_wd    = '0;
    case (state)
      S_INIT: begin
        // Chains 1 -> 2 -> ... -> DEPTH-1 -> 0; the +1 wraps to null on the last entry
        mem_we = 1'b1;
        mem_wa = init_ptr;
        mem_wd = {SUIT_W'(0), VALUE_W'(0), init_ptr + AW'(1)};
        if (init_last) state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (cmd_valid && cmd_op != OP_NOP) begin
          if (!list_ok)             state_nxt = S_RESP;
          else if (cmd_op == OP_INS) state_nxt = S_ALLOC;
          else                      state_nxt = S_WALK;
        end
      end
      S_ALLOC: begin
        if (free_count != '0) begin
          mem_we = 1'b1;
          mem_wa = free_head;
          mem_wd = {suit_q, value_q, head[list_q]};
        end
        state_nxt = S_RESP;
      end
      S_WALK: begin
        if (cur == '0)         state_nxt = S_RESP;
        else if (cnt == idx_q) state_nxt = (op_q == OP_REM) ? S_UNLINK : S_RESP;
      end
      S_UNLINK: begin
        if (idx_q != '0) begin
          mem_we = 1'b1;
          mem_wa = prev;
          mem_wd = {prev_suit, prev_value, cur_next};
        end
        state_nxt = S_FREE;
      end
      S_FREE: begin
        mem_we    = 1'b1;
        mem_wa    = cur;
        mem_wd    = {res_suit, res_value, free_head};
        state_nxt = S_IDLE;
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      init_ptr   <= AW'(1);
      free_head  <= '0;
      free_count <= '0;
      init_done  <= 1'b0;
      head       <= '0;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_value  <= '0;
      rsp_suit   <= '0;
    end else begin
      // FREE both returns the entry and issues the response, saving a cycle on REMOVE
      rsp_valid <= (state == S_RESP) || (state == S_FREE);
      if (state == S_RESP || state == S_FREE) begin
        rsp_err   <= err_q;
        rsp_value <= res_value;
        rsp_suit  <= res_suit;
      end
      case (state)
        S_INIT: begin
          init_ptr <= init_ptr + AW'(1);
          if (init_last) begin
            free_head  <= AW'(1);
            free_count <= FW'(DEPTH - 1);
            init_done  <= 1'b1;
          end
        end
        S_ALLOC: begin
          if (free_count != '0) begin
            head[list_q] <= free_head;
            free_head    <= rd_next;
            free_count   <= free_count - FW'(1);
          end
        end
        S_UNLINK: begin
          if (idx_q == '0) head[list_q] <= cur_next;
        end
        S_FREE: begin
          free_head  <= cur;
          free_count <= free_count + FW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          op_q      <= cmd_op;
          list_q    <= cmd_list;
          idx_q     <= cmd_idx;
          value_q   <= cmd_value;
          suit_q    <= cmd_suit;
          cur       <= head[cmd_list];
          prev      <= '0;
          cnt       <= '0;
          err_q     <= !list_ok;
          res_value <= '0;
          res_suit  <= '0;
        end
      end
      S_ALLOC: begin
        if (free_count == '0) begin
          err_q     <= 1'b1;
          res_value <= '0;
          res_suit  <= '0;
        end else begin
          err_q     <= 1'b0;
          res_value <= value_q;
          res_suit  <= suit_q;
        end
      end
      S_WALK: begin
        if (cur == '0) begin
          err_q     <= 1'b1;
          res_value <= '0;
          res_suit  <= '0;
        end else if (cnt == idx_q) begin
          err_q     <= 1'b0;
          res_value <= rd_value;
          res_suit  <= rd_suit;
          cur_next  <= rd_next;
        end else begin
          prev       <= cur;
          prev_value <= rd_value;
          prev_suit  <= rd_suit;
          cur        <= rd_next;
          cnt        <= cnt + IDX_W'(1);
        end
      end
      default: ;
    endcase
  end

endmodule
